// File: rtl/bp_pkg.sv
// Shared types and defaults for the branch predictor slice.
// Holds the in-flight queue entry layout, the 2-bit saturating counter type
// and its update function. Entry fields are sized to the widest supported
// configuration (PC_W <= 16, HIST_W <= 8). The top stores narrower values in
// the low bits of each field.
package bp_pkg;

    localparam int BP_QUEUE_DEPTH = 4;
    localparam int BP_HIST_W      = 3;
    localparam int BP_PC_W        = 10;

    // Widest PC and history that a queue entry can carry.
    localparam int ENT_PC_MAX_W   = 16;
    localparam int ENT_HIST_MAX_W = 8;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_WEAK_NT = 2'b01;

    typedef struct packed {
        logic [ENT_PC_MAX_W-1:0]   pc;
        logic [ENT_HIST_MAX_W-1:0] idx;
        logic                      hit;
        logic                      pred;
    } bp_entry_t;

    // Saturating 2-bit counter: move towards 3 on taken, towards 0 on not-taken.
    function automatic ctr_t ctr_update(input ctr_t c, input logic taken);
        ctr_t r;
        if (taken) begin
            r = (c == 2'b11) ? c : c + 2'b01;
        end else begin
            r = (c == 2'b00) ? c : c - 2'b01;
        end
        return r;
    endfunction

endpackage

// File: rtl/bp_queue.sv
// In-order FIFO of in-flight branches for the predictor.
// Supports push, pop and flush. A flush discards every entry at the edge
// (count=0, head moves onto tail) and drops a push in the same cycle.
// A push and a pop together are accepted even when the queue is full.
// The head entry is visible combinationally on head_data.
module bp_queue
    import bp_pkg::*;
#(
    parameter int DEPTH = BP_QUEUE_DEPTH
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  logic      flush,
    input  bp_entry_t push_data,
    output bp_entry_t head_data,
    output logic      full,
    output logic      empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    bp_entry_t        mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign head_data = mem_q[head_q];

    // Accept/flush decisions and next pointer and count values.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && !flush && (!full || do_pop);
        head_d  = head_q + PTR_W'(do_pop);
        tail_d  = tail_q + PTR_W'(do_push);
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        if (flush) begin
            // The push is dropped, so tail stays where it is and head joins it.
            head_d  = tail_q;
            tail_d  = tail_q;
            count_d = '0;
        end
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage. Slots are only read while the count marks them valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[tail_q] <= push_data;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Two-level branch predictor with a 2-bit-counter pattern history table.
// The history comes from an external history cache.
// Each fetched conditional branch is predicted combinationally and queued.
// When it resolves, it trains the PHT, writes the history cache, and flushes
// the queue if the prediction was wrong.
// Optional feature: define BP_PC_HASH_EN to index the PHT with
// read_history XOR the low PC bits (gshare-style).
module branch_predictor
    import bp_pkg::*;
#(
    parameter int QUEUE_DEPTH = BP_QUEUE_DEPTH,
    parameter int HIST_W      = BP_HIST_W,
    parameter int PC_W        = BP_PC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_valid,
    input  logic              fetch_branch,
    input  logic [PC_W-1:0]   fetch_pc,
    input  logic              read_hit,
    input  logic [HIST_W-1:0] read_history,
    input  logic              resolve_valid,
    input  logic              resolve_taken,
    output logic              predict_taken,
    output logic              stall,
    output logic              mispredict,
    output logic              cache_we,
    output logic              cache_branch_taken,
    output logic [PC_W-1:0]   cache_update_pc,
    output logic              resolve_err
);

    localparam int PHT_N = 1 << HIST_W;

    logic [HIST_W-1:0] idx;
    ctr_t              pht_q [PHT_N];
    ctr_t              pht_d [PHT_N];

    bp_entry_t         push_data;
    bp_entry_t         head;
    logic              q_full;
    logic              q_empty;
    logic              pop;
    logic              mismatch;
    logic              push_req;
    logic [HIST_W-1:0] head_idx;
    logic [PC_W-1:0]   head_pc;

    logic              mispredict_q, mispredict_d;
    logic              cache_we_q, cache_we_d;
    logic              cache_taken_q, cache_taken_d;
    logic [PC_W-1:0]   cache_pc_q, cache_pc_d;
    logic              resolve_err_q, resolve_err_d;

    // The entry fields are sized for the widest configuration. Fold the whole head into one bit so that the unread upper bits stay visible.
    logic              unused_head_bits;

    // PHT index for the current fetch.
    always_comb begin
`ifdef BP_PC_HASH_EN
        idx = read_history ^ fetch_pc[HIST_W-1:0];
`else
        idx = read_history;
`endif
    end

    // Prediction is static not-taken unless this is a branch that hits in the history cache.
    assign predict_taken = read_hit && fetch_branch && pht_q[idx][1];
    assign stall         = q_full;

    // Resolve, mismatch and push decisions for this cycle.
    always_comb begin
        pop      = resolve_valid && !q_empty;
        mismatch = pop && (resolve_taken != head.pred);
        push_req = fetch_valid && fetch_branch && !mismatch && (!q_full || pop);
        head_idx = head.idx[HIST_W-1:0];
        head_pc  = head.pc[PC_W-1:0];
    end

    assign unused_head_bits = ^head;

    // Pack the fetched branch into a queue entry.
    always_comb begin
        push_data                  = '0;
        push_data.pc[PC_W-1:0]     = fetch_pc;
        push_data.idx[HIST_W-1:0]  = idx;
        push_data.hit              = read_hit;
        push_data.pred             = predict_taken;
    end

    bp_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .pop       (pop),
        .flush     (mismatch),
        .push_data (push_data),
        .head_data (head),
        .full      (q_full),
        .empty     (q_empty)
    );

    // PHT training from the resolving head. Entries that missed in the history cache do not train.
    always_comb begin
        pht_d = pht_q;
        if (pop && head.hit) begin
            pht_d[head_idx] = ctr_update(pht_q[head_idx], resolve_taken);
        end
    end

    // PHT state, initialised to weak not-taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PHT_N; i++) begin
                pht_q[i] <= CTR_WEAK_NT;
            end
        end else begin
            pht_q <= pht_d;
        end
    end

    // Next values of the registered resolve-side outputs.
    always_comb begin
        mispredict_d  = mismatch;
        cache_we_d    = pop;
        cache_taken_d = pop ? resolve_taken : cache_taken_q;
        cache_pc_d    = pop ? head_pc : cache_pc_q;
        resolve_err_d = resolve_err_q || (resolve_valid && q_empty);
    end

    // Registered resolve-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mispredict_q  <= 1'b0;
            cache_we_q    <= 1'b0;
            cache_taken_q <= 1'b0;
            cache_pc_q    <= '0;
            resolve_err_q <= 1'b0;
        end else begin
            mispredict_q  <= mispredict_d;
            cache_we_q    <= cache_we_d;
            cache_taken_q <= cache_taken_d;
            cache_pc_q    <= cache_pc_d;
            resolve_err_q <= resolve_err_d;
        end
    end

    assign mispredict         = mispredict_q;
    assign cache_we           = cache_we_q;
    assign cache_branch_taken = cache_taken_q;
    assign cache_update_pc    = cache_pc_q;
    assign resolve_err        = resolve_err_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor.
// The stimulus process drives one fetch/resolve cycle at a time and updates a
// queue-based reference model. Each expected history cache write goes into a
// scoreboard. The monitor pops and compares the scoreboard on every cache write.
module tb_branch_predictor;

    localparam int D  = 4;
    localparam int HW = 3;
    localparam int PW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fetch_valid = 1'b0;
    logic          fetch_branch = 1'b0;
    logic [PW-1:0] fetch_pc = '0;
    logic          read_hit = 1'b0;
    logic [HW-1:0] read_history = '0;
    logic          resolve_valid = 1'b0;
    logic          resolve_taken = 1'b0;
    logic          predict_taken;
    logic          stall;
    logic          mispredict;
    logic          cache_we;
    logic          cache_branch_taken;
    logic [PW-1:0] cache_update_pc;
    logic          resolve_err;

    always #5 clk = ~clk;

    branch_predictor #(.QUEUE_DEPTH(D), .HIST_W(HW), .PC_W(PW)) dut (
        .clk                (clk),
        .rst                (rst),
        .fetch_valid        (fetch_valid),
        .fetch_branch       (fetch_branch),
        .fetch_pc           (fetch_pc),
        .read_hit           (read_hit),
        .read_history       (read_history),
        .resolve_valid      (resolve_valid),
        .resolve_taken      (resolve_taken),
        .predict_taken      (predict_taken),
        .stall              (stall),
        .mispredict         (mispredict),
        .cache_we           (cache_we),
        .cache_branch_taken (cache_branch_taken),
        .cache_update_pc    (cache_update_pc),
        .resolve_err        (resolve_err)
    );

    typedef struct {
        logic [PW-1:0] pc;
        logic [HW-1:0] idx;
        bit            hit;
        bit            pred;
    } m_ent_t;

    typedef struct {
        logic [PW-1:0] pc;
        bit            taken;
        bit            mis;
    } sb_t;

    m_ent_t inflight[$];
    sb_t    sb[$];
    int     pht_m [1 << HW];
    bit     err_m = 1'b0;
    bit     mon_en = 1'b0;
    int     n_checks = 0;
    int     n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[%0t] FAIL %s: got %0h, expected %0h", $time, name, act, exp);
        end
    endtask

    task automatic set_idle();
        fetch_valid   = 1'b0;
        fetch_branch  = 1'b0;
        fetch_pc      = '0;
        read_hit      = 1'b0;
        read_history  = '0;
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;
    endtask

    // Reset asserted between edges: outputs must clear without waiting for a clock.
    task automatic do_reset();
        @(negedge clk);
        set_idle();
        #2;
        err_m = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_mispredict", mispredict, 0);
        chk("rst_cache_we", cache_we, 0);
        chk("rst_cache_taken", cache_branch_taken, 0);
        chk("rst_cache_pc", cache_update_pc, 0);
        chk("rst_resolve_err", resolve_err, 0);
        chk("rst_stall", stall, 0);
        inflight.delete();
        for (int i = 0; i < (1 << HW); i++) pht_m[i] = 1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // One cycle of stimulus followed by the reference model update.
    task automatic step(input bit fv, input bit fb, input logic [PW-1:0] pc, input bit hit,
                        input logic [HW-1:0] hist, input bit rv, input bit rt);
        logic [HW-1:0] idx;
        bit exp_pred, was_full, popped, mis;
        m_ent_t h;
        @(negedge clk);
        fetch_valid   = fv;
        fetch_branch  = fb;
        fetch_pc      = pc;
        read_hit      = hit;
        read_history  = hist;
        resolve_valid = rv;
        resolve_taken = rt;
        #1;
`ifdef BP_PC_HASH_EN
        idx = hist ^ pc[HW-1:0];
`else
        idx = hist;
`endif
        exp_pred = hit && fb && (pht_m[idx] >= 2);
        chk("predict_taken", predict_taken, exp_pred);
        chk("stall", stall, inflight.size() == D);
        was_full = (inflight.size() == D);
        popped = 0;
        mis = 0;
        if (rv) begin
            if (inflight.size() == 0) begin
                err_m = 1'b1;
            end else begin
                h = inflight.pop_front();
                popped = 1;
                mis = (rt != h.pred);
                if (h.hit) begin
                    if (rt) pht_m[h.idx] = (pht_m[h.idx] < 3) ? pht_m[h.idx] + 1 : 3;
                    else    pht_m[h.idx] = (pht_m[h.idx] > 0) ? pht_m[h.idx] - 1 : 0;
                end
                sb.push_back('{pc: h.pc, taken: rt, mis: mis});
                if (mis) inflight.delete();
            end
        end
        if (fv && fb && !mis && (!was_full || popped))
            inflight.push_back('{pc: pc, idx: idx, hit: hit, pred: exp_pred});
    endtask

    // Monitor: every cache write must match the oldest expected resolve.
    initial begin
        sb_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (cache_we) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_cache_we", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        $display("[%0t] cache write pc=%h taken=%0d mispredict=%0d",
                                 $time, cache_update_pc, cache_branch_taken, mispredict);
                        chk("cache_update_pc", cache_update_pc, e.pc);
                        chk("cache_branch_taken", cache_branch_taken, e.taken);
                        chk("mispredict", mispredict, e.mis);
                    end
                end else begin
                    chk("mispredict_idle", mispredict, 0);
                end
                chk("resolve_err", resolve_err, err_m);
            end
        end
    end

    initial begin
        do_reset();
        mon_en = 1'b1;

        // First branch predicted not-taken, resolves taken: mispredict and train PHT[5] to 2.
        step(1, 1, 10'h013, 1, 3'b101, 0, 0);
        step(0, 0, 10'h000, 0, 3'b000, 1, 1);
        // Three more taken resolves saturate the counter at 3.
        repeat (3) begin
            step(1, 1, 10'h013, 1, 3'b101, 0, 0);
            step(0, 0, 10'h000, 0, 3'b000, 1, 1);
        end
        step(0, 1, 10'h013, 1, 3'b101, 0, 0);
        // Five not-taken resolves drive the counter to 0, where it stays.
        repeat (5) begin
            step(1, 1, 10'h013, 1, 3'b101, 0, 0);
            step(0, 0, 10'h000, 0, 3'b000, 1, 0);
        end
        step(0, 1, 10'h013, 1, 3'b101, 0, 0);

        // Fill the queue, then push together with a resolve while full.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 1, PW'(10'h040 + i), 0, 3'b000, 0, 0);
        step(1, 1, 10'h100, 0, 3'b000, 1, 0);
        step(0, 0, 10'h000, 0, 3'b000, 0, 0);
        repeat (4) step(0, 0, 10'h000, 0, 3'b000, 1, 0);

        // Three queued branches. The head mispredicts while a push is requested.
        repeat (3) step(1, 1, PW'($urandom), 0, 3'b000, 0, 0);
        step(1, 1, 10'h155, 0, 3'b000, 1, 1);
        // The queue is now empty, so this resolve sets the sticky error flag.
        step(0, 0, 10'h000, 0, 3'b000, 1, 0);
        repeat (3) step(1, 1, PW'($urandom), 1, HW'($urandom), 0, 0);
        repeat (3) step(0, 0, 10'h000, 0, 3'b000, 1, 0);

        // Branch at pc 0x006 with history 101. With hashing enabled this trains PHT index 3.
        do_reset();
        step(1, 1, 10'h006, 1, 3'b101, 0, 0);
        step(0, 0, 10'h000, 0, 3'b000, 1, 1);
        step(0, 1, 10'h006, 1, 3'b101, 0, 0);
        step(0, 1, 10'h000, 1, 3'b011, 0, 0);
        // Leave entries in flight and reset asynchronously.
        repeat (3) step(1, 1, PW'($urandom), 1, HW'($urandom), 0, 0);
        do_reset();

        // Randomised traffic, with one asynchronous reset in the middle.
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            step(($urandom % 4) != 0, ($urandom % 3) != 0, PW'($urandom), ($urandom % 4) != 0,
                 HW'($urandom % 4), ($urandom % 3) == 0, $urandom % 2);
        end
        repeat (3) step(0, 0, 10'h000, 0, 3'b000, 0, 0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 4, giving the in-flight branch queue depth (power of two, 2..8).
REQ-002 SHALL have parameter HIST_W, default 3, giving the history width; the PHT holds 2^HIST_W entries.
REQ-003 SHALL have parameter PC_W, default 10, giving the program counter width.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 fetch_valid  in  1  a fetch-stage instruction is presented this cycle.
REQ-007 fetch_branch  in  1  the fetched instruction is a conditional branch.
REQ-008 fetch_pc  in  PC_W  fetch PC; also drives the history cache read PC.
REQ-009 read_hit  in  1  history cache hit for fetch_pc.
REQ-010 read_history  in  HIST_W  history cache history for fetch_pc.
REQ-011 resolve_valid  in  1  the oldest in-flight branch resolves in execute this cycle.
REQ-012 resolve_taken  in  1  actual outcome of the resolving branch.
REQ-013 predict_taken  out  1  combinational prediction for the current fetch.
REQ-014 stall  out  1  queue full; fetch must hold.
REQ-015 mispredict  out  1  registered one-cycle pulse; the pipeline must flush and redirect.
REQ-016 cache_we, cache_branch_taken  out  1 each  registered history cache write strobe and outcome.
REQ-017 cache_update_pc  out  PC_W  registered PC of the resolved branch, for the history cache update index.
REQ-018 resolve_err  out  1  sticky flag: resolve_valid was asserted while the queue was empty.

Function
REQ-019 predict_taken SHALL be PHT[idx] bit 1 when read_hit=1 and fetch_branch=1, else 0 (static not-taken on a miss).
REQ-020 idx SHALL equal read_history, except as modified by REQ-035.
REQ-021 A push SHALL occur when fetch_valid and fetch_branch are both 1, stall=0, and no flush is in effect.
REQ-022 A push SHALL store {fetch_pc, idx, read_hit, predict_taken} at the tail.
REQ-023 A pop of the head SHALL occur when resolve_valid=1 and the queue is non-empty.
REQ-024 A simultaneous push and pop SHALL be legal at any occupancy, including full.
REQ-025 stall SHALL equal (count==QUEUE_DEPTH) and be combinational from the registered count.
REQ-026 A mismatch SHALL be detected when a pop occurs and resolve_taken != head.pred.
REQ-027 On a mismatch, mispredict SHALL be 1 in the next cycle only.
REQ-028 On a mismatch, all remaining entries SHALL be discarded at the same edge (count=0, head=tail).
REQ-029 A push requested in the mismatch cycle SHALL be dropped, since it is wrong-path.
REQ-030 On a pop where head.hit=1, PHT[head.idx] SHALL saturate-increment if taken and saturate-decrement if not; 3 and 0 SHALL hold.
REQ-031 On a pop, the next cycle SHALL have cache_we=1, cache_branch_taken=resolve_taken, cache_update_pc=head.pc; otherwise cache_we=0.
REQ-032 On resolve_valid with an empty queue: no state change except resolve_err<=1; mispredict and cache_we SHALL stay 0.
REQ-033 Head and tail pointers SHALL wrap modulo QUEUE_DEPTH; count SHALL have log2(QUEUE_DEPTH)+1 bits.

Reset
REQ-034 While rst=0: queue empty, pointers 0, PHT all 2'b01 (weak not-taken), mispredict=0, cache_we=0, cache_branch_taken=0, cache_update_pc=0, resolve_err=0.
A reset mid-operation SHALL discard in-flight entries without any cache write.

Configuration
REQ-035 With macro BP_PC_HASH_EN defined, idx SHALL be read_history XOR fetch_pc[HIST_W-1:0] (gshare-style); without it, idx = read_history. No other behaviour differs.

Structure
REQ-036 Package bp_pkg SHALL hold the HIST_W/PC_W defaults, the queue entry struct {pc, idx, hit, pred}, and the 2-bit counter typedef with the saturating update function.
REQ-037 The queue SHALL be the sub-module bp_queue (push/pop/flush, full/empty, head data out); the PHT and control logic SHALL reside in branch_predictor.

Verification
REQ-038 After reset, fetch a branch at pc=0x013 with read_hit=1, history=3'b101 -> predict_taken=0, pushed; resolve taken -> mispredict=1 one cycle later, cache_we=1, cache_update_pc=0x013, PHT[5]=2.
REQ-039 Resolve the same index taken 3 more times -> PHT[5] saturates at 3, predict_taken=1 for history 101; 4 not-taken resolves -> 0, then stays 0.
REQ-040 Push 4 branches with no resolve -> stall=1 after the 4th; push plus resolve while full -> count stays 4, stall stays 1.
REQ-041 Queue holds 3 entries, head mispredicts while a push is requested -> mispredict pulse, count=0, push dropped, only 1 cache write.
REQ-042 resolve_valid with an empty queue -> resolve_err=1 sticky until reset, cache_we=0, mispredict=0.
REQ-043 With BP_PC_HASH_EN, pc=0x006, history=3'b101 -> PHT index 3 updated; assert rst=0 mid-queue -> all outputs at reset values asynchronously.
